bayer_demosaic_stream: RTL

Streaming 2x2 Bayer demosaic for the camera path, running entirely in the `clk` domain.
- Raw sensor pixels arrive with a `pixel_valid` strobe, framed by `lv`/`fv`.
- One RGB pixel is produced per 2x2 Bayer quad (half resolution in each axis), while the odd line is still arriving. There is no post-line processing burst.
- The Bayer phase, pixel width and line length are parameters. The crop window is set at run time.
- Output feeds the frame-buffer writer as an address plus write strobe.

---
 rtl/bayer_pkg.sv | 43 ++++
 rtl/bayer_line_buffer.sv | 23 ++
 rtl/bayer_demosaic_stream.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bayer_pkg.sv
// Shared Bayer types, the CFA phase-to-channel mapping and the white-balance unity constant.
package bayer_pkg;

   typedef enum logic [1:0] {
      RGGB = 2'd0,
      GRBG = 2'd1,
      GBRG = 2'd2,
      BGGR = 2'd3
   } bayer_pattern_t;

   typedef enum logic [1:0] {
      CH_R = 2'd0,
      CH_G = 2'd1,
      CH_B = 2'd2
   } bayer_channel_t;

   localparam int WB_UNITY = 64;
   localparam int WB_FRAC  = 6;

   // Red sits at the phase named by the pattern, blue diagonally opposite, green elsewhere.
   function automatic bayer_channel_t bayer_channel(bayer_pattern_t pat, logic row, logic col);
      logic [1:0] pos;
      logic [1:0] red_pos;
      bayer_channel_t ch;
      pos = {row, col};
      case (pat)
         RGGB:    red_pos = 2'b00;
         GRBG:    red_pos = 2'b01;
         GBRG:    red_pos = 2'b10;
         BGGR:    red_pos = 2'b11;
         default: red_pos = 2'b00;
      endcase
      if (pos == red_pos) begin
         ch = CH_R;
      end else if (pos == ~red_pos) begin
         ch = CH_B;
      end else begin
         ch = CH_G;
      end
      return ch;
   endfunction

endpackage

// File: rtl/bayer_line_buffer.sv
// One-line pixel store with registered read; one shared address, never read and written together.
module bayer_line_buffer #(
   parameter int DW    = 10,
   parameter int HSIZE = 1288
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(HSIZE)-1:0]   addr,
   input  logic [DW-1:0]              wdata,
   output logic [DW-1:0]              rdata
);

   logic [DW-1:0] mem [HSIZE];

   // RAM write port and registered read port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/bayer_demosaic_stream.sv
// Streaming 2x2 Bayer demosaic with crop window and linear frame-buffer addressing.
// Optional white-balance gain stage: define BAYER_DEMOSAIC_WB_GAIN_EN.
module bayer_demosaic_stream
   import bayer_pkg::*;
#(
   parameter int DW      = 10,
   parameter int HSIZE   = 1288,
   parameter int PATTERN = 0,
   parameter int CW      = 11,
   parameter int ADDR_W  = 18
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [DW-1:0]       pixel_data,
   input  logic                pixel_valid,
   input  logic                lv,
   input  logic                fv,
   input  logic [CW-1:0]       crop_x0,
   input  logic [CW-1:0]       crop_y0,
   input  logic [CW-1:0]       crop_w,
   input  logic [CW-1:0]       crop_h,
`ifdef BAYER_DEMOSAIC_WB_GAIN_EN
   input  logic [7:0]          gain_r,
   input  logic [7:0]          gain_g,
   input  logic [7:0]          gain_b,
`endif
   output logic [3*DW-1:0]     rgb,
   output logic [7:0]          rgb8,
   output logic [ADDR_W-1:0]   address,
   output logic                wr_en,
   output logic                frame_done,
   output logic                overflow
);

   localparam int COLW = $clog2(HSIZE + 1);
   localparam int AW   = $clog2(HSIZE);
   localparam int LW   = CW + 2;
   localparam int QW   = CW + 1;
   localparam bayer_pattern_t PAT = bayer_pattern_t'(PATTERN[1:0]);

   logic              fv_d_r, lv_d_r, active_r;
   logic [COLW-1:0]   col_r;
   logic [LW-1:0]     line_r;
   logic [CW-1:0]     crop_x0_r, crop_y0_r, crop_w_r, crop_h_r;
   logic              s1_valid_r, s1_odd_r, s1_win_r;
   logic [DW-1:0]     s1_pix_r, top_even_r, bot_even_r;
   logic [ADDR_W-1:0] addr_r;

   logic              fv_rise_s, fv_fall_s, lv_fall_s, pix_s, acc_s, win_s, fire_s;
   logic [QW-1:0]     qx_s, qy_s;
   logic [DW-1:0]     lb_rdata_s, r_s, g_s, b_s;
   logic [DW:0]       gsum_s;
   logic [DW-1:0]     samp_s [4];
   logic              fin_valid_s;
   logic [DW-1:0]     fin_r_s, fin_g_s, fin_b_s;
   logic [ADDR_W-1:0] fin_addr_s;

   // Edge detection, pixel acceptance and crop-window test
   always_comb begin
      fv_rise_s = fv && !fv_d_r;
      fv_fall_s = !fv && fv_d_r;
      lv_fall_s = !lv && lv_d_r;
      // a strobe in the cycle lv drops still belongs to the ending line
      pix_s     = active_r && fv && (lv || lv_d_r) && pixel_valid;
      acc_s     = pix_s && (col_r < COLW'(HSIZE));
      qx_s      = QW'(col_r >> 1);
      qy_s      = line_r[LW-1:1];
      win_s     = (qx_s >= {1'b0, crop_x0_r}) && (qx_s < ({1'b0, crop_x0_r} + {1'b0, crop_w_r})) &&
                  (qy_s >= {1'b0, crop_y0_r}) && (qy_s < ({1'b0, crop_y0_r} + {1'b0, crop_h_r}));
   end

   // Frame/line framing, counters, crop capture, overflow and frame_done
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fv_d_r     <= 1'b1;  // a frame may only start from a genuinely observed fv rise
         lv_d_r     <= 1'b0;
         active_r   <= 1'b0;
         col_r      <= '0;
         line_r     <= '0;
         crop_x0_r  <= '0;
         crop_y0_r  <= '0;
         crop_w_r   <= '0;
         crop_h_r   <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         fv_d_r     <= fv;
         lv_d_r     <= lv;
         frame_done <= active_r && fv_fall_s;
         if (fv_rise_s) begin
            active_r  <= 1'b1;
            col_r     <= '0;
            line_r    <= '0;
            overflow  <= 1'b0;
            crop_x0_r <= crop_x0;
            crop_y0_r <= crop_y0;
            crop_w_r  <= crop_w;
            crop_h_r  <= crop_h;
         end else if (fv_fall_s) begin
            active_r <= 1'b0;
            col_r    <= '0;
            line_r   <= '0;
         end else begin
            if (pix_s && !acc_s) begin
               overflow <= 1'b1;
            end
            if (active_r && lv_fall_s) begin
               col_r  <= '0;
               line_r <= line_r + LW'(1'b1);
            end else if (acc_s) begin
               col_r <= col_r + COLW'(1'b1);
            end
         end
      end
   end

   bayer_line_buffer #(.DW(DW), .HSIZE(HSIZE)) u_line_buffer (
      .clk   (clk),
      .we    (acc_s && !line_r[0]),
      .addr  (AW'(col_r)),
      .wdata (pixel_data),
      .rdata (lb_rdata_s)
   );

   // Stage 1: odd-line pixel alongside the buffered even-line pixel of the same column
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_r <= 1'b0;
         s1_odd_r   <= 1'b0;
         s1_win_r   <= 1'b0;
         s1_pix_r   <= '0;
      end else begin
         s1_valid_r <= acc_s && line_r[0];
         s1_odd_r   <= col_r[0];
         s1_win_r   <= win_s;
         s1_pix_r   <= pixel_data;
      end
   end

   // Even-column half of the quad, held until its odd-column partner arrives
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         top_even_r <= '0;
         bot_even_r <= '0;
      end else if (fv_rise_s || fv_fall_s) begin
         top_even_r <= '0;
         bot_even_r <= '0;
      end else if (s1_valid_r && !s1_odd_r) begin
         top_even_r <= lb_rdata_s;
         bot_even_r <= s1_pix_r;
      end else begin
         top_even_r <= top_even_r;
         bot_even_r <= bot_even_r;
      end
   end

   // Quad assembly: sample index is {row, col} within the quad
   always_comb begin
      samp_s[0] = top_even_r;
      samp_s[1] = lb_rdata_s;
      samp_s[2] = bot_even_r;
      samp_s[3] = s1_pix_r;
      r_s       = '0;
      b_s       = '0;
      gsum_s    = '0;
      for (int i = 0; i < 4; i++) begin
         case (bayer_channel(PAT, i[1], i[0]))
            CH_R:    r_s    = samp_s[i];
            CH_B:    b_s    = samp_s[i];
            CH_G:    gsum_s = gsum_s + {1'b0, samp_s[i]};
            default: gsum_s = gsum_s;
         endcase
      end
      g_s    = gsum_s[DW:1];
      fire_s = s1_valid_r && s1_odd_r && s1_win_r;
   end

   // Write address: restarts every frame, advances once per emitted pixel
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_r <= '0;
      end else if (fv_rise_s || fv_fall_s) begin
         addr_r <= '0;
      end else if (fire_s) begin
         addr_r <= addr_r + ADDR_W'(1'b1);
      end else begin
         addr_r <= addr_r;
      end
   end

`ifdef BAYER_DEMOSAIC_WB_GAIN_EN
   logic [7:0]        gain_r_r, gain_g_r, gain_b_r;
   logic              p2_valid_r;
   logic [DW-1:0]     p2_r_r, p2_g_r, p2_b_r;
   logic [ADDR_W-1:0] p2_addr_r;

   function automatic logic [DW-1:0] apply_gain(logic [DW-1:0] v, logic [7:0] gain);
      logic [DW+7:0] prod;
      prod = ({8'd0, v} * {{DW{1'b0}}, gain}) >> WB_FRAC;
      return (|prod[DW+7:DW]) ? {DW{1'b1}} : prod[DW-1:0];
   endfunction

   // Gains are frame-constant, captured together with the crop window
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gain_r_r <= 8'(WB_UNITY);
         gain_g_r <= 8'(WB_UNITY);
         gain_b_r <= 8'(WB_UNITY);
      end else if (fv_rise_s) begin
         gain_r_r <= gain_r;
         gain_g_r <= gain_g;
         gain_b_r <= gain_b;
      end else begin
         gain_r_r <= gain_r_r;
         gain_g_r <= gain_g_r;
         gain_b_r <= gain_b_r;
      end
   end

   // Stage 2: demosaiced pixel registered ahead of the gain multipliers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p2_valid_r <= 1'b0;
         p2_r_r     <= '0;
         p2_g_r     <= '0;
         p2_b_r     <= '0;
         p2_addr_r  <= '0;
      end else begin
         p2_valid_r <= fire_s;
         p2_r_r     <= r_s;
         p2_g_r     <= g_s;
         p2_b_r     <= b_s;
         p2_addr_r  <= addr_r;
      end
   end

   // Gain-scaled channels feeding the output register
   always_comb begin
      fin_valid_s = p2_valid_r;
      fin_r_s     = apply_gain(p2_r_r, gain_r_r);
      fin_g_s     = apply_gain(p2_g_r, gain_g_r);
      fin_b_s     = apply_gain(p2_b_r, gain_b_r);
      fin_addr_s  = p2_addr_r;
   end
`else
   // Channels pass straight to the output register
   always_comb begin
      fin_valid_s = fire_s;
      fin_r_s     = r_s;
      fin_g_s     = g_s;
      fin_b_s     = b_s;
      fin_addr_s  = addr_r;
   end
`endif

   // Registered frame-buffer write port; data forced to zero between writes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_en   <= 1'b0;
         rgb     <= '0;
         rgb8    <= '0;
         address <= '0;
      end else begin
         wr_en <= fin_valid_s;
         if (fin_valid_s) begin
            rgb     <= {fin_r_s, fin_g_s, fin_b_s};
            rgb8    <= {fin_r_s[DW-1-:3], fin_g_s[DW-1-:3], fin_b_s[DW-1-:2]};
            address <= fin_addr_s;
         end else begin
            rgb     <= '0;
            rgb8    <= '0;
            address <= address;
         end
      end
   end

endmodule
